// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - opcodes and FSM state type for the split add/sub engine
package calc_pkg;
  localparam logic [2:0] SIGN_ADD = 3'd3;
  localparam logic [2:0] SIGN_SUB = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/addsub_slice.sv
// rtl/addsub_slice.sv - half-width adder slice: a + (inv ? ~b : b) + cin
module addsub_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         inv_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);
  logic [W-1:0] b_eff;

  assign b_eff = inv_i ? ~b_i : b_i;
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{W{1'b0}}, cin_i};
endmodule

// File: rtl/split_addsub_seq.sv
// rtl/split_addsub_seq.sv - two-phase add/subtract on one half-width slice, low half first
module split_addsub_seq
  import calc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       sign,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             led2,
  output logic             err,
  output logic             islow,
  output logic [2:0]       sign_o,
  output logic             half_carry
);
  localparam int HALF = WIDTH / 2;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [2:0]       sign_q;
  logic             c_q, carry_q, led2_q, err_q, busy_q, done_q, islow_q;

  logic            legal, is_sub;
  logic [HALF-1:0] slice_a_d, slice_b_d, slice_sum;
  logic            slice_cin_d, slice_cout;

  assign legal  = (sign_q == SIGN_ADD) || (sign_q == SIGN_SUB);
  assign is_sub = (sign_q == SIGN_SUB);

  // The single slice is shared: low halves plus the subtract's +1 first, then high halves plus c_q.
  assign slice_a_d   = (state_q == LOW) ? a_q[HALF-1:0] : a_q[WIDTH-1:HALF];
  assign slice_b_d   = (state_q == LOW) ? b_q[HALF-1:0] : b_q[WIDTH-1:HALF];
  assign slice_cin_d = (state_q == LOW) ? is_sub : c_q;

  addsub_slice #(.W(HALF)) u_slice (
    .a_i    (slice_a_d),
    .b_i    (slice_b_d),
    .inv_i  (is_sub),
    .cin_i  (slice_cin_d),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  assign half_carry = legal && ((state_q == LOW) || (state_q == HIGH)) && slice_cout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= '0;
      c_q      <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      led2_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      islow_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q      <= op_a;
            b_q      <= op_b;
            sign_q   <= sign;
            result_q <= '0;
            carry_q  <= 1'b0;
            led2_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b1;
            islow_q  <= 1'b1;
            state_q  <= LOW;
          end
        end
        LOW: begin
          if (legal) begin
            result_q[HALF-1:0] <= slice_sum;
            c_q                <= slice_cout;
          end
          islow_q <= 1'b0;
          state_q <= HIGH;
        end
        HIGH: begin
          // Illegal opcodes still take the full latency but leave result/flags at zero.
          if (legal) begin
            result_q[WIDTH-1:HALF] <= slice_sum;
            carry_q                <= slice_cout;
            led2_q                 <= is_sub ? ~slice_cout : slice_cout;
          end else begin
            err_q <= 1'b1;
          end
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          sign_q  <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_q;
  assign led2      = led2_q;
  assign err       = err_q;
  assign islow     = islow_q;
  assign sign_o    = sign_q;
endmodule

// File: tb/tb_split_addsub_seq.sv
// tb/tb_split_addsub_seq.sv - directed self-checking bench for split_addsub_seq
module tb_split_addsub_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  sign = 3'd0;
  logic [15:0] op_a = 16'h0;
  logic [15:0] op_b = 16'h0;
  logic        busy, done, carry_out, led2, err, islow, half_carry;
  logic [15:0] result;
  logic [2:0]  sign_o;

  int tests_run = 0;
  int tests_failed = 0;

  split_addsub_seq #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sign       (sign),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .carry_out  (carry_out),
    .led2       (led2),
    .err        (err),
    .islow      (islow),
    .sign_o     (sign_o),
    .half_carry (half_carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 10) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Returns edges from the accept edge (counted as 1) to the first sample showing done.
  task automatic run_op(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b,
                        output int lat, output logic lo_hc, output logic lo_islow,
                        output logic [2:0] lo_sign);
    wait_idle();
    sign = s; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    lo_hc = half_carry;
    lo_islow = islow;
    lo_sign = sign_o;
    while (!done && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  int         lat, dones;
  logic       hc, il;
  logic [2:0] so;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_flags", {carry_out, led2, err, islow, half_carry}, 0);
    check("rst_sign_o", sign_o, 0);
    rst = 1'b0;

    run_op(3'd3, 16'h00FF, 16'h0001, lat, hc, il, so);
    check("add1_lat", lat, 3);
    check("add1_lo_hc", hc, 1);
    check("add1_islow", il, 1);
    check("add1_sign_o", so, 3);
    check("add1_result", result, 16'h0100);
    check("add1_co_led", {carry_out, led2, err}, 3'b000);
    check("add1_busy_done", busy, 1);
    @(posedge clk); #1;
    check("add1_after_done", {busy, done}, 2'b00);
    check("add1_held", result, 16'h0100);
    check("idle_sign_o", sign_o, 0);

    run_op(3'd3, 16'hFFFF, 16'h0001, lat, hc, il, so);
    check("add2_lat", lat, 3);
    check("add2_result", result, 16'h0000);
    check("add2_co_led_err", {carry_out, led2, err}, 3'b110);

    run_op(3'd4, 16'h1234, 16'h1234, lat, hc, il, so);
    check("sub1_result", result, 16'h0000);
    check("sub1_co_led", {carry_out, led2}, 2'b10);

    run_op(3'd4, 16'h0001, 16'h0002, lat, hc, il, so);
    check("sub2_result", result, 16'hFFFF);
    check("sub2_co_led", {carry_out, led2}, 2'b01);

    // New requests while busy must be ignored.
    wait_idle();
    sign = 3'd3; op_a = 16'h0010; op_b = 16'h0020; start = 1'b1;
    @(posedge clk); #1;
    sign = 3'd4; op_a = 16'hFFFF; op_b = 16'h1111;
    dones = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    start = 1'b0;
    check("ign_result", result, 16'h0030);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("ign_one_done", dones, 1);
    check("ign_held", result, 16'h0030);

    run_op(3'd5, 16'h0003, 16'h0004, lat, hc, il, so);
    check("ill_lat", lat, 3);
    check("ill_result", result, 16'h0000);
    check("ill_flags", {err, led2, carry_out}, 3'b100);
    check("ill_lo_hc", hc, 0);
    run_op(3'd3, 16'h0001, 16'h0001, lat, hc, il, so);
    check("clr_err", err, 0);
    check("clr_result", result, 16'h0002);

    // Reset during HIGH.
    wait_idle();
    sign = 3'd3; op_a = 16'hFFFF; op_b = 16'h0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_busy_done", {busy, done}, 2'b00);
    check("rst_mid_result", result, 0);
    check("rst_mid_flags", {carry_out, led2, err, islow, half_carry, sign_o}, 0);
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("rst_mid_no_done", dones, 0);

    // start coincident with rst is dropped.
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("rst_start_drop", busy, 0);

    run_op(3'd3, 16'h0002, 16'h0003, lat, hc, il, so);
    check("post_rst_lat", lat, 3);
    check("post_rst_result", result, 16'h0005);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
